game_sequencer: RTL and testbench
=================================

// Module: game_sequencer
// PURPOSE
//  Top-level round/match controller for two-player Tron. Drives Game_State, which the
//  score, bike and render blocks consume. Sequences title -> countdown -> play ->
//  round-end pause -> next round, or match-end on a win. Consumes score's reset_round,
//  Blue_W and Red_W. Issues one-cycle respawn pulses and freezes bikes outside play.
// PARAMETERS
//  COUNTDOWN_FRAMES  180  frames spent in COUNTDOWN before PLAY (3 s @ 60 Hz)
//  ROUND_END_FRAMES  90   frames frozen after a crash before the next COUNTDOWN
//  MATCH_END_FRAMES  600  frames in MATCH_END before auto-return to TITLE
//  CW                10   frame counter width; must hold max(*_FRAMES)-1
// PORTS
//  Clk              in   1  50 MHz system clock
//  Reset            in   1  synchronous, active-high reset
//  frame_clk        in   1  ~60 Hz vsync-derived frame clock, asynchronous to Clk
//  start_key        in   1  level input from keyboard decode (Enter held)
//  reset_round      in   1  one-cycle pulse from score: a bike crashed
//  Blue_W, Red_W    in   1  level inputs from score: match won
//  Game_State       out  3  TITLE=0 COUNTDOWN=1 PLAY=2 ROUND_END=3 MATCH_END=4
//  freeze_bikes     out  1  1 in every state except PLAY
//  respawn          out  1  one-cycle pulse: bikes/trails return to start positions
//  countdown_digit  out  2  3,2,1 during COUNTDOWN; 0 otherwise
//  winner           out  2  00 none, 01 blue, 10 red, 11 draw; valid in MATCH_END
// BEHAVIOUR
//  Reset (any state, mid-round included): state=TITLE next cycle, frame_cnt=0,
//   start_prev=1. Outputs: Game_State=0, freeze_bikes=1, respawn=0,
//   countdown_digit=0, winner=00. Sync regs cleared.
//  frame_tick: frame_clk goes through a 2-flop synchroniser, then rising-edge detect.
//   Tick is a 1-Clk pulse, 3 Clk after the frame_clk rise.
//  start_edge = start_key & ~start_prev. Only edges act; a held key never retriggers.
//  Timed states: on entry frame_cnt <= N-1. On each tick: leave if frame_cnt==0,
//   else decrement. Exactly N ticks are spent in the state.
//  TITLE: start_edge -> COUNTDOWN, with a respawn pulse in the same cycle as the change.
//  COUNTDOWN: countdown_digit = 3 - (elapsed*3)/COUNTDOWN_FRAMES. Use a compare ladder,
//   no divider. Expiry -> PLAY.
//  PLAY: freeze_bikes=0.
//   Blue_W|Red_W -> MATCH_END. This has priority over reset_round in the same cycle.
//   Otherwise reset_round -> ROUND_END.
//  ROUND_END: expiry -> COUNTDOWN plus respawn pulse.
//   If Blue_W|Red_W rises first -> MATCH_END immediately.
//  MATCH_END: winner latched on entry: Red_W->01, Blue_W->10, both->11.
//   Note score's Red_W means blue scored 3.
//   start_edge or expiry -> TITLE. The TITLE code clears score.
//  reset_round pulses outside PLAY/ROUND_END are ignored.
//   A second pulse in ROUND_END does not restart the timer.
//  start_edge outside TITLE/MATCH_END is ignored.
//  Game_State, freeze_bikes and countdown_digit are registered.
//   They reflect the new state the cycle after the transition.
//  respawn is registered, high exactly 1 Clk per entry to COUNTDOWN.
//  Encodings 5-7 are unreachable and decode to TITLE.
// STRUCTURE
//  tron_pkg: game_state_t enum (3-bit, values above), winner codes, default frame
//   constants. Shared with score and bike controllers.
//  Sub-module frame_tick_gen: synchroniser + edge detect; ports Clk, Reset,
//   frame_clk, frame_tick.
//  Top: one FSM always_ff plus next-state always_comb; frame counter; start edge reg.
// TESTING
//  1 Reset in PLAY, then release -> Game_State=0, freeze=1, winner=00, respawn=0.
//  2 TITLE, start_edge -> 1 respawn pulse; COUNTDOWN, digits 3,2,1 for 60 ticks each.
//    PLAY entered on tick 180; freeze=0.
//  3 PLAY, reset_round pulse -> ROUND_END for 90 ticks -> COUNTDOWN, respawn once.
//  4 PLAY, reset_round and Red_W in same cycle -> MATCH_END, winner=01.
//    Start held through -> no retrigger; new edge -> TITLE.
//  5 Blue_W=Red_W=1 in PLAY -> winner=11.
//    600 ticks with no start -> TITLE on the 600th tick.
//  6 frame_clk jittered or async to Clk -> exactly one tick per rising edge.
//    No ticks while frame_clk stays high.

Source files
------------

// File: rtl/tron_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tron_pkg
//  Description : Shared game-state encoding, winner codes and frame timing
//                defaults for the two-player Tron sequencer, score and bikes.
//  Revision    : 1.0  initial release
// ============================================================================
package tron_pkg;

    typedef enum logic [2:0] {
        ST_TITLE     = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_PLAY      = 3'd2,
        ST_ROUND_END = 3'd3,
        ST_MATCH_END = 3'd4
    } game_state_t;

    localparam logic [1:0] c_win_none = 2'b00;
    localparam logic [1:0] c_win_blue = 2'b01;
    localparam logic [1:0] c_win_red  = 2'b10;
    localparam logic [1:0] c_win_draw = 2'b11;

    localparam int c_def_countdown_frames = 180;
    localparam int c_def_round_end_frames = 90;
    localparam int c_def_match_end_frames = 600;
    localparam int c_def_cw               = 10;

    // Score reports the loser's side: Red_W means blue reached the win count.
    function automatic logic [1:0] winner_code(input logic blue_w, input logic red_w);
        logic [1:0] code;
        case ({blue_w, red_w})
            2'b01:   code = c_win_blue;
            2'b10:   code = c_win_red;
            2'b11:   code = c_win_draw;
            default: code = c_win_none;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/game_sequencer_frame_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : frame_tick_gen
//  Description : Brings the asynchronous frame clock into the Clk domain and
//                emits a single-cycle tick per rising edge.
//  Revision    : 1.0  initial release
// ============================================================================
module frame_tick_gen (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic frame_tick
);

    logic r_sync1;
    logic r_sync2;
    logic r_sync_prev;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_sync_prev <= 1'b0;
            frame_tick  <= 1'b0;
        end else begin
            r_sync1     <= frame_clk;
            r_sync2     <= r_sync1;
            r_sync_prev <= r_sync2;
            frame_tick  <= r_sync2 & ~r_sync_prev;
        end
    end

endmodule
`default_nettype wire

// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : game_sequencer
//  Description : Round/match controller for two-player Tron: title, countdown,
//                play, round-end pause and match-end sequencing.
//  Revision    : 1.0  initial release
// ============================================================================
module game_sequencer
    import tron_pkg::*;
#(
    parameter int COUNTDOWN_FRAMES = c_def_countdown_frames,
    parameter int ROUND_END_FRAMES = c_def_round_end_frames,
    parameter int MATCH_END_FRAMES = c_def_match_end_frames,
    parameter int CW               = c_def_cw
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       start_key,
    input  logic       reset_round,
    input  logic       Blue_W,
    input  logic       Red_W,
    output logic [2:0] Game_State,
    output logic       freeze_bikes,
    output logic       respawn,
    output logic [1:0] countdown_digit,
    output logic [1:0] winner
);

    localparam logic [CW-1:0] c_cd_last = CW'(COUNTDOWN_FRAMES - 1);
    localparam logic [CW-1:0] c_re_last = CW'(ROUND_END_FRAMES - 1);
    localparam logic [CW-1:0] c_me_last = CW'(MATCH_END_FRAMES - 1);
    localparam logic [CW+1:0] c_cd_t1   = (CW+2)'(COUNTDOWN_FRAMES);
    localparam logic [CW+1:0] c_cd_t2   = (CW+2)'(2 * COUNTDOWN_FRAMES);

    game_state_t   r_state;
    game_state_t   w_next_state;
    logic [CW-1:0] r_frame_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [CW-1:0] w_elapsed;
    logic [CW+1:0] w_elapsed3;
    logic [1:0]    w_digit_next;
    logic [1:0]    w_winner_next;
    logic          r_start_prev;
    logic          w_start_edge;
    logic          w_tick;
    logic          w_expire;
    logic          w_win;
    logic          w_respawn_next;

    frame_tick_gen u_frame_tick_gen (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .frame_tick (w_tick)
    );

    assign w_start_edge = start_key & ~r_start_prev;
    assign w_expire     = w_tick && (r_frame_cnt == '0);
    assign w_win        = Blue_W | Red_W;

    always_comb begin
        w_next_state   = ST_TITLE;
        w_respawn_next = 1'b0;
        case (r_state)
            ST_TITLE: begin
                if (w_start_edge) begin
                    w_next_state   = ST_COUNTDOWN;
                    w_respawn_next = 1'b1;
                end else begin
                    w_next_state = ST_TITLE;
                end
            end
            ST_COUNTDOWN: begin
                w_next_state = w_expire ? ST_PLAY : ST_COUNTDOWN;
            end
            ST_PLAY: begin
                if (w_win)
                    w_next_state = ST_MATCH_END;
                else if (reset_round)
                    w_next_state = ST_ROUND_END;
                else
                    w_next_state = ST_PLAY;
            end
            ST_ROUND_END: begin
                if (w_win) begin
                    w_next_state = ST_MATCH_END;
                end else if (w_expire) begin
                    w_next_state   = ST_COUNTDOWN;
                    w_respawn_next = 1'b1;
                end else begin
                    w_next_state = ST_ROUND_END;
                end
            end
            ST_MATCH_END: begin
                w_next_state = (w_start_edge || w_expire) ? ST_TITLE : ST_MATCH_END;
            end
            default: begin
                w_next_state = ST_TITLE;
            end
        endcase
    end

    // Every timed state is entered with N-1 so that exactly N ticks elapse.
    always_comb begin
        w_cnt_next = r_frame_cnt;
        if (w_next_state != r_state) begin
            case (w_next_state)
                ST_COUNTDOWN: w_cnt_next = c_cd_last;
                ST_ROUND_END: w_cnt_next = c_re_last;
                ST_MATCH_END: w_cnt_next = c_me_last;
                default:      w_cnt_next = '0;
            endcase
        end else if (w_tick && (r_frame_cnt != '0)) begin
            w_cnt_next = r_frame_cnt - CW'(1);
        end
    end

    // digit = 3 - floor(3*elapsed/N), resolved by comparing 3*elapsed to N and 2N.
    always_comb begin
        w_elapsed    = c_cd_last - w_cnt_next;
        w_elapsed3   = {2'b00, w_elapsed} + {1'b0, w_elapsed, 1'b0};
        w_digit_next = 2'd0;
        if (w_next_state == ST_COUNTDOWN) begin
            if (w_elapsed3 < c_cd_t1)
                w_digit_next = 2'd3;
            else if (w_elapsed3 < c_cd_t2)
                w_digit_next = 2'd2;
            else
                w_digit_next = 2'd1;
        end
    end

    always_comb begin
        w_winner_next = c_win_none;
        if (w_next_state == ST_MATCH_END) begin
            if (r_state != ST_MATCH_END)
                w_winner_next = winner_code(Blue_W, Red_W);
            else
                w_winner_next = winner;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state         <= ST_TITLE;
            r_frame_cnt     <= '0;
            r_start_prev    <= 1'b1;
            Game_State      <= ST_TITLE;
            freeze_bikes    <= 1'b1;
            respawn         <= 1'b0;
            countdown_digit <= 2'd0;
            winner          <= c_win_none;
        end else begin
            r_state         <= w_next_state;
            r_frame_cnt     <= w_cnt_next;
            r_start_prev    <= start_key;
            Game_State      <= w_next_state;
            freeze_bikes    <= (w_next_state != ST_PLAY);
            respawn         <= w_respawn_next;
            countdown_digit <= w_digit_next;
            winner          <= w_winner_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_game_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_game_sequencer
//  Description : Self-checking bench for game_sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_game_sequencer;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_clk = 1'b0;
    logic       start_key = 1'b0;
    logic       reset_round = 1'b0;
    logic       Blue_W = 1'b0;
    logic       Red_W = 1'b0;
    logic [2:0] Game_State;
    logic       freeze_bikes;
    logic       respawn;
    logic [1:0] countdown_digit;
    logic [1:0] winner;

    int checks = 0;
    int errors = 0;
    int respawn_cnt = 0;
    int rs_before;

    localparam logic [2:0] TITLE = 3'd0, CD = 3'd1, PLAY = 3'd2, RE = 3'd3, ME = 3'd4;

    typedef struct {
        logic [2:0] st;
        logic       frz;
        logic [1:0] dig;
        logic [1:0] win;
    } exp_t;

    typedef struct {
        logic       rr;
        logic       bw;
        logic       rw;
        logic [2:0] st;
        logic [1:0] win;
    } vec_t;

    exp_t  sbq[$];
    string nameq[$];
    vec_t  vecs[5];

    game_sequencer dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .frame_clk       (frame_clk),
        .start_key       (start_key),
        .reset_round     (reset_round),
        .Blue_W          (Blue_W),
        .Red_W           (Red_W),
        .Game_State      (Game_State),
        .freeze_bikes    (freeze_bikes),
        .respawn         (respawn),
        .countdown_digit (countdown_digit),
        .winner          (winner)
    );

    always #10 Clk = ~Clk;

    always @(posedge Clk) if (respawn) respawn_cnt++;

    task automatic cyc(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic tick();
        frame_clk = 1'b1; cyc(4);
        frame_clk = 1'b0; cyc(4);
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic press();
        start_key = 1'b1; cyc(1);
        start_key = 1'b0; cyc(1);
    endtask

    task automatic do_reset();
        Reset = 1'b1; cyc(3);
        Reset = 1'b0; cyc(1);
    endtask

    task automatic go_play();
        do_reset();
        press();
        ticks(180);
    endtask

    task automatic push_exp(input string n, input logic [2:0] st,
                            input logic [1:0] dig, input logic [1:0] win);
        exp_t e;
        e.st  = st;
        e.frz = (st != PLAY);
        e.dig = dig;
        e.win = win;
        sbq.push_back(e);
        nameq.push_back(n);
    endtask

    task automatic check_pop();
        exp_t  e;
        string n;
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: queue empty at compare time");
        end else begin
            e = sbq.pop_front();
            n = nameq.pop_front();
            if (Game_State !== e.st || freeze_bikes !== e.frz ||
                countdown_digit !== e.dig || winner !== e.win) begin
                errors++;
                $display("FAIL %s: got st=%0d frz=%0b dig=%0d win=%b, want st=%0d frz=%0b dig=%0d win=%b",
                         n, Game_State, freeze_bikes, countdown_digit, winner,
                         e.st, e.frz, e.dig, e.win);
            end
        end
    endtask

    task automatic chk(input string n, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", n, act, want);
        end
    endtask

    task automatic async_pulse();
        #($urandom_range(1, 19));
        frame_clk = 1'b1;
        #(20 * $urandom_range(4, 30) + $urandom_range(0, 19));
        frame_clk = 1'b0;
        #(20 * $urandom_range(4, 12) + $urandom_range(0, 19));
        @(negedge Clk);
    endtask

    initial begin
        vecs[0] = '{rr: 1'b1, bw: 1'b0, rw: 1'b0, st: RE,   win: 2'b00};
        vecs[1] = '{rr: 1'b1, bw: 1'b0, rw: 1'b1, st: ME,   win: 2'b01};
        vecs[2] = '{rr: 1'b0, bw: 1'b1, rw: 1'b0, st: ME,   win: 2'b10};
        vecs[3] = '{rr: 1'b0, bw: 1'b1, rw: 1'b1, st: ME,   win: 2'b11};
        vecs[4] = '{rr: 1'b0, bw: 1'b0, rw: 1'b0, st: PLAY, win: 2'b00};

        @(negedge Clk);
        do_reset();
        push_exp("reset_state", TITLE, 2'd0, 2'b00);
        check_pop();
        chk("reset_respawn", int'(respawn), 0);

        // Title ignores crashes and wins.
        push_exp("title_ignores_rr", TITLE, 2'd0, 2'b00);
        reset_round = 1'b1; Blue_W = 1'b1; cyc(1);
        reset_round = 1'b0; Blue_W = 1'b0; cyc(1);
        check_pop();

        // Countdown digit sequence and single respawn.
        rs_before = respawn_cnt;
        push_exp("countdown_entry", CD, 2'd3, 2'b00);
        press();
        check_pop();
        chk("start_respawn_once", respawn_cnt - rs_before, 1);
        for (int i = 1; i <= 180; i++) begin
            tick();
            if (i == 30) begin
                push_exp("start_ignored_in_cd", CD, 2'd3, 2'b00);
                press();
                check_pop();
            end
            if (i == 59 || i == 60 || i == 119 || i == 120 || i == 179) begin
                push_exp($sformatf("cd_tick_%0d", i), CD, 2'(3 - (i * 3) / 180), 2'b00);
                check_pop();
            end
        end
        push_exp("play_after_180", PLAY, 2'd0, 2'b00);
        check_pop();
        chk("cd_no_extra_respawn", respawn_cnt - rs_before, 1);

        // Reset in the middle of a round.
        Reset = 1'b1; cyc(1);
        push_exp("reset_mid_play", TITLE, 2'd0, 2'b00);
        check_pop();
        Reset = 1'b0; cyc(1);
        push_exp("after_reset_release", TITLE, 2'd0, 2'b00);
        check_pop();
        chk("after_reset_respawn", int'(respawn), 0);

        // One-cycle input combinations applied in PLAY.
        for (int v = 0; v < 5; v++) begin
            go_play();
            push_exp($sformatf("play_vec_%0d", v), vecs[v].st, 2'd0, vecs[v].win);
            reset_round = vecs[v].rr; Blue_W = vecs[v].bw; Red_W = vecs[v].rw;
            cyc(1);
            reset_round = 1'b0;
            check_pop();
            Blue_W = 1'b0; Red_W = 1'b0;
            cyc(1);
        end

        // Round-end pause: 90 ticks, second crash ignored, respawn once.
        go_play();
        reset_round = 1'b1; cyc(1); reset_round = 1'b0;
        ticks(45);
        reset_round = 1'b1; cyc(1); reset_round = 1'b0;
        ticks(44);
        push_exp("round_end_tick_89", RE, 2'd0, 2'b00);
        check_pop();
        rs_before = respawn_cnt;
        tick();
        push_exp("round_end_expiry", CD, 2'd3, 2'b00);
        check_pop();
        chk("round_end_respawn_once", respawn_cnt - rs_before, 1);

        // Win during the round-end pause.
        go_play();
        reset_round = 1'b1; cyc(1); reset_round = 1'b0;
        ticks(10);
        Blue_W = 1'b1; cyc(1);
        push_exp("win_in_round_end", ME, 2'd0, 2'b10);
        check_pop();
        Blue_W = 1'b0; cyc(1);

        // Start held across match end never retriggers.
        go_play();
        start_key = 1'b1; cyc(2);
        push_exp("start_ignored_in_play", PLAY, 2'd0, 2'b00);
        check_pop();
        reset_round = 1'b1; Red_W = 1'b1; cyc(1);
        reset_round = 1'b0; Red_W = 1'b0;
        push_exp("match_end_red_w", ME, 2'd0, 2'b01);
        check_pop();
        cyc(5);
        push_exp("held_start_no_retrigger", ME, 2'd0, 2'b01);
        check_pop();
        start_key = 1'b0; cyc(1);
        push_exp("new_start_edge_title", TITLE, 2'd0, 2'b00);
        press();
        check_pop();

        // Draw and match-end timeout.
        go_play();
        Blue_W = 1'b1; Red_W = 1'b1; cyc(1);
        push_exp("draw", ME, 2'd0, 2'b11);
        check_pop();
        Blue_W = 1'b0; Red_W = 1'b0;
        ticks(599);
        push_exp("match_end_tick_599", ME, 2'd0, 2'b11);
        check_pop();
        tick();
        push_exp("match_end_timeout", TITLE, 2'd0, 2'b00);
        check_pop();

        // Asynchronous, jittered frame clock: one tick per rising edge.
        do_reset();
        press();
        repeat (59) async_pulse();
        cyc(6);
        push_exp("async_59_edges", CD, 2'd3, 2'b00);
        check_pop();
        async_pulse();
        cyc(6);
        push_exp("async_60_edges", CD, 2'd2, 2'b00);
        check_pop();

        chk("scoreboard_drained", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
